// File: rtl/llr_word_packer_if.sv
// rtl/llr_word_packer_if.sv - packed-word output stream bundle for llr_word_packer
//
// Purpose: carries one packed LLR word plus framing flags from the packer to
//          its consumer. A word transfers on a cycle where oval & ordy.
// Signals:
//   odata - packed word, LLR k at bits [W*k+W-1 : W*k], unused bits zero
//   ocnt  - number of valid LLRs in odata
//   osof  - first word of a frame
//   olast - last word of a frame
//   oval  - word valid
//   ordy  - consumer ready
interface llr_word_packer_if;
    logic [31:0] odata;
    logic [2:0]  ocnt;
    logic        osof;
    logic        olast;
    logic        oval;
    logic        ordy;

    modport master (
        output odata,
        output ocnt,
        output osof,
        output olast,
        output oval,
        input  ordy
    );

    modport slave (
        input  odata,
        input  ocnt,
        input  osof,
        input  olast,
        input  oval,
        output ordy
    );
endinterface

// File: rtl/llr_word_packer.sv
// rtl/llr_word_packer.sv - packs serial soft-bit LLRs into framed 32-bit words
//
// Purpose: collects pLLR_PER_WORD LLRs into one word, frames words on
//          pFRAME_LLR-LLR boundaries and buffers them in an output FIFO
//          whose head is held in registers.
// Ports:
//   clk, rst      - clock, synchronous active-high reset
//   illr          - soft bit from the RX serializer
//   ival          - illr valid, no backpressure
//   isof          - first LLR of a frame (qualified by ival)
//   m_ax          - packed-word output stream (master side)
//   oovf          - sticky: a word was dropped on a full FIFO
//   ofrm_err      - sticky: a frame was cut short by an early isof
// Parameters assume pLLR_PER_WORD >= 2, pFRAME_LLR >= 2 and
// pLLR_W * pLLR_PER_WORD <= 32.
module llr_word_packer #(
    parameter int pLLR_W        = 5,
    parameter int pLLR_PER_WORD = 6,
    parameter int pFRAME_LLR    = 4800,
    parameter int pFIFO_DEPTH   = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [pLLR_W-1:0]    illr,
    input  logic                 ival,
    input  logic                 isof,
    llr_word_packer_if.master    m_ax,
    output logic                 oovf,
    output logic                 ofrm_err
);

    localparam int ACC_W = pLLR_W * pLLR_PER_WORD;
    localparam int FW    = $clog2(pLLR_PER_WORD + 1);
    localparam int CW    = $clog2(pFRAME_LLR + 1);
    localparam int AW    = (pFIFO_DEPTH > 1) ? $clog2(pFIFO_DEPTH) : 1;

    localparam logic [0:0]    WAIT_SOF  = 1'b0;
    localparam logic [0:0]    PACK      = 1'b1;
    localparam logic [FW-1:0] FILL_FULL = FW'(pLLR_PER_WORD);
    localparam logic [CW-1:0] FRAME_END = CW'(pFRAME_LLR);
    localparam logic [AW:0]   FIFO_FULL = (AW + 1)'(pFIFO_DEPTH);
    localparam logic [AW-1:0] PTR_LAST  = AW'(pFIFO_DEPTH - 1);

    typedef struct packed {
        logic [31:0] data;
        logic [2:0]  cnt;
        logic        sof;
        logic        last;
    } word_t;

    function automatic word_t make_word(logic [ACC_W-1:0] acc, logic [FW-1:0] fill,
                                        logic sof, logic last);
        word_t w;
        w.data            = '0;
        w.data[ACC_W-1:0] = acc;
        w.cnt             = 3'(fill);
        w.sof             = sof;
        w.last            = last;
        return w;
    endfunction

    function automatic logic [AW-1:0] ptr_inc(logic [AW-1:0] p);
        return (p == PTR_LAST) ? '0 : p + AW'(1);
    endfunction

    // ------------------------------------------------------------------
    // Packer
    // ------------------------------------------------------------------
    logic [0:0]       state_q, state_d;
    logic [ACC_W-1:0] acc_q, acc_d;
    logic [FW-1:0]    fill_q, fill_d;
    logic [CW-1:0]    frm_cnt_q, frm_cnt_d;
    logic             sof_pend_q, sof_pend_d;
    logic             frm_err_q, frm_err_d;
    logic             push_q, push_d;
    word_t            push_word_q, push_word_d;

    // Accumulator view after a possible frame (re)start, before the new LLR lands
    logic [ACC_W-1:0] acc_b;
    logic [FW-1:0]    fill_b;
    logic [CW-1:0]    cnt_b;
    logic             sof_b;
    logic             start;
    logic             accept;

    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        fill_d      = fill_q;
        frm_cnt_d   = frm_cnt_q;
        sof_pend_d  = sof_pend_q;
        frm_err_d   = frm_err_q;
        push_d      = 1'b0;
        push_word_d = push_word_q;

        start  = ival & isof;
        accept = ival & (isof | (state_q == PACK));

        acc_b  = acc_q;
        fill_b = fill_q;
        cnt_b  = frm_cnt_q;
        sof_b  = sof_pend_q;

        if (start) begin
            // Early restart: flush the pending partial word, if any, as the
            // truncated frame's last word. An empty accumulator means the
            // cut landed on a word boundary and nothing is reported.
            if ((state_q == PACK) && (fill_q != '0)) begin
                push_d      = 1'b1;
                push_word_d = make_word(acc_q, fill_q, sof_pend_q, 1'b1);
                frm_err_d   = 1'b1;
            end
            acc_b  = '0;
            fill_b = '0;
            cnt_b  = '0;
            sof_b  = 1'b1;
        end

        if (accept) begin
            acc_d = acc_b;
            for (int k = 0; k < pLLR_PER_WORD; k++) begin
                if (fill_b == FW'(k)) begin
                    acc_d[k*pLLR_W +: pLLR_W] = illr;
                end
            end
            fill_d     = fill_b + FW'(1);
            frm_cnt_d  = cnt_b + CW'(1);
            sof_pend_d = sof_b;
            state_d    = PACK;

            if ((fill_d == FILL_FULL) || (frm_cnt_d == FRAME_END)) begin
                push_d      = 1'b1;
                push_word_d = make_word(acc_d, fill_d, sof_b, frm_cnt_d == FRAME_END);
                acc_d       = '0;
                fill_d      = '0;
                sof_pend_d  = 1'b0;
                if (frm_cnt_d == FRAME_END) begin
                    frm_cnt_d = '0;
                    state_d   = WAIT_SOF;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= WAIT_SOF;
            acc_q       <= '0;
            fill_q      <= '0;
            frm_cnt_q   <= '0;
            sof_pend_q  <= 1'b0;
            frm_err_q   <= 1'b0;
            push_q      <= 1'b0;
            push_word_q <= '0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            fill_q      <= fill_d;
            frm_cnt_q   <= frm_cnt_d;
            sof_pend_q  <= sof_pend_d;
            frm_err_q   <= frm_err_d;
            push_q      <= push_d;
            push_word_q <= push_word_d;
        end
    end

    // ------------------------------------------------------------------
    // Output FIFO. fifo_cnt counts every stored word including the one
    // presented in head_q, so head_q always mirrors mem_q[rd_ptr_q].
    // ------------------------------------------------------------------
    word_t          mem_q [pFIFO_DEPTH];
    logic [AW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [AW:0]    fifo_cnt_q, fifo_cnt_d;
    logic           ovf_q, ovf_d;
    logic           head_vld_q, head_vld_d;
    word_t          head_q, head_d;
    logic           pop;
    logic           wr_en;

    always_comb begin
        pop   = head_vld_q & m_ax.ordy;
        // A full FIFO still accepts a word when the head leaves this cycle
        wr_en = push_q & ((fifo_cnt_q != FIFO_FULL) | pop);
        ovf_d = ovf_q | (push_q & ~wr_en);

        wr_ptr_d = wr_en ? ptr_inc(wr_ptr_q) : wr_ptr_q;
        rd_ptr_d = pop   ? ptr_inc(rd_ptr_q) : rd_ptr_q;

        case ({wr_en, pop})
            2'b10:   fifo_cnt_d = fifo_cnt_q + (AW + 1)'(1);
            2'b01:   fifo_cnt_d = fifo_cnt_q - (AW + 1)'(1);
            default: fifo_cnt_d = fifo_cnt_q;
        endcase

        head_vld_d = (fifo_cnt_d != '0);
        head_d     = '0;
        if (fifo_cnt_d != '0) begin
            // The next head is the word being written when it lands in the
            // slot the read pointer will point at (FIFO empty or draining).
            if (wr_en && (wr_ptr_q == rd_ptr_d)) begin
                head_d = push_word_q;
            end else begin
                head_d = mem_q[rd_ptr_d];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_ptr_q] <= push_word_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            fifo_cnt_q <= '0;
            ovf_q      <= 1'b0;
            head_vld_q <= 1'b0;
            head_q     <= '0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            fifo_cnt_q <= fifo_cnt_d;
            ovf_q      <= ovf_d;
            head_vld_q <= head_vld_d;
            head_q     <= head_d;
        end
    end

    assign m_ax.oval  = head_vld_q;
    assign m_ax.odata = head_q.data;
    assign m_ax.ocnt  = head_q.cnt;
    assign m_ax.osof  = head_q.sof;
    assign m_ax.olast = head_q.last;
    assign oovf       = ovf_q;
    assign ofrm_err   = frm_err_q;

endmodule

// File: tb/tb_llr_word_packer.sv
// tb/tb_llr_word_packer.sv - scoreboard bench for llr_word_packer (12- and 8-LLR frames)
module tb_llr_word_packer;

    logic       clk  = 1'b0;
    logic       rst  = 1'b1;
    logic [4:0] illr = '0;
    logic       ival = 1'b0;
    logic       isof = 1'b0;
    logic       ordy = 1'b1;
    logic       oovf0, oovf1, ferr0, ferr1;

    llr_word_packer_if ax0 ();
    llr_word_packer_if ax1 ();
    assign ax0.ordy = ordy;
    assign ax1.ordy = ordy;

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    llr_word_packer #(.pLLR_W(5), .pLLR_PER_WORD(6), .pFRAME_LLR(12), .pFIFO_DEPTH(4)) u_dut0 (
        .clk(clk), .rst(rst), .illr(illr), .ival(ival), .isof(isof),
        .m_ax(ax0), .oovf(oovf0), .ofrm_err(ferr0)
    );

    llr_word_packer #(.pLLR_W(5), .pLLR_PER_WORD(6), .pFRAME_LLR(8), .pFIFO_DEPTH(4)) u_dut1 (
        .clk(clk), .rst(rst), .illr(illr), .ival(ival), .isof(isof),
        .m_ax(ax1), .oovf(oovf1), .ofrm_err(ferr1)
    );

    typedef struct packed {
        logic [31:0] data;
        logic [2:0]  cnt;
        logic        sof;
        logic        last;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];

    int total = 0;
    int bad   = 0;

    int          fl [2] = '{12, 8};
    bit          m_pack [2];
    int          m_fill [2];
    int          m_cnt  [2];
    int          m_occ  [2];
    int          xfer   [2];
    logic        m_sof  [2];
    logic        m_err  [2];
    logic        m_ovf  [2];
    logic [31:0] m_acc  [2];

    int lat_ref = 0;
    bit lat_arm = 1'b0;

    task automatic check(string tag, logic [63:0] got, logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    task automatic emit(int i, logic [31:0] d, int n, logic s, logic l);
        exp_t e;
        if (m_occ[i] >= 4) begin
            m_ovf[i] = 1'b1;
            return;
        end
        e.data = d;
        e.cnt  = 3'(n);
        e.sof  = s;
        e.last = l;
        m_occ[i]++;
        if (i == 0) q0.push_back(e);
        else        q1.push_back(e);
    endtask

    task automatic model_llr(int i, logic [4:0] v, bit s);
        if (!m_pack[i] && !s) return;
        if (s) begin
            if (m_pack[i] && m_fill[i] != 0) begin
                emit(i, m_acc[i], m_fill[i], m_sof[i], 1'b1);
                m_err[i] = 1'b1;
            end
            m_acc[i]  = '0;
            m_fill[i] = 0;
            m_cnt[i]  = 0;
            m_sof[i]  = 1'b1;
            m_pack[i] = 1'b1;
        end
        m_acc[i] = m_acc[i] | (32'(v) << (5 * m_fill[i]));
        m_fill[i]++;
        m_cnt[i]++;
        if (m_fill[i] == 6 || m_cnt[i] == fl[i]) begin
            emit(i, m_acc[i], m_fill[i], m_sof[i], m_cnt[i] == fl[i]);
            m_acc[i]  = '0;
            m_fill[i] = 0;
            m_sof[i]  = 1'b0;
            if (m_cnt[i] == fl[i]) begin
                m_pack[i] = 1'b0;
                m_cnt[i]  = 0;
            end
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_pack[i] = 1'b0;
            m_fill[i] = 0;
            m_cnt[i]  = 0;
            m_occ[i]  = 0;
            m_sof[i]  = 1'b0;
            m_err[i]  = 1'b0;
            m_ovf[i]  = 1'b0;
            m_acc[i]  = '0;
        end
        q0.delete();
        q1.delete();
    endtask

    task automatic mon_pop(int i, logic [31:0] d, logic [2:0] c, logic s, logic l);
        exp_t e;
        if (i == 0) begin
            if (q0.size() == 0) begin
                check("extra_word0", q0.size(), 1);
                return;
            end
            e = q0.pop_front();
        end else begin
            if (q1.size() == 0) begin
                check("extra_word1", q1.size(), 1);
                return;
            end
            e = q1.pop_front();
        end
        check($sformatf("data%0d", i), d, e.data);
        check($sformatf("cnt%0d", i), c, e.cnt);
        check($sformatf("sof%0d", i), s, e.sof);
        check($sformatf("last%0d", i), l, e.last);
        m_occ[i]--;
        xfer[i]++;
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            if (lat_arm && ax0.oval) begin
                check("latency", cyc - lat_ref + 1, 2);
                lat_arm = 1'b0;
            end
            if (ax0.oval && ordy) mon_pop(0, ax0.odata, ax0.ocnt, ax0.osof, ax0.olast);
            if (ax1.oval && ordy) mon_pop(1, ax1.odata, ax1.ocnt, ax1.osof, ax1.olast);
        end
    end

    task automatic send(logic [4:0] v, bit s);
        illr = v;
        isof = s;
        ival = 1'b1;
        @(posedge clk);
        model_llr(0, v, s);
        model_llr(1, v, s);
        #1;
        ival = 1'b0;
        isof = 1'b0;
    endtask

    task automatic idle(int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_frame(int n, bit rnd);
        for (int k = 1; k <= n; k++) begin
            send(rnd ? 5'($urandom_range(0, 31)) : 5'(k), k == 1);
        end
    endtask

    task automatic drain(int max);
        int w = 0;
        while ((q0.size() != 0 || q1.size() != 0) && w < max) begin
            @(posedge clk);
            w++;
        end
        #1;
        check("drain_left", q0.size() + q1.size(), 0);
        idle(3);
        check("idle_oval", {ax0.oval, ax1.oval}, 2'b00);
    endtask

    task automatic check_reset_outputs(string tag);
        check({tag, "0"}, {ax0.oval, ax0.odata, ax0.ocnt, ax0.osof, ax0.olast, oovf0, ferr0}, '0);
        check({tag, "1"}, {ax1.oval, ax1.odata, ax1.ocnt, ax1.osof, ax1.olast, oovf1, ferr1}, '0);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

    initial begin
        model_reset();
        rst  = 1'b1;
        ordy = 1'b1;
        idle(3);
        check_reset_outputs("reset_out");
        rst = 1'b0;
        idle(1);

        // Pre-sync LLRs are discarded, then a counted frame; latency on word 0
        for (int k = 0; k < 5; k++) send(5'(20 + k), 1'b0);
        for (int k = 1; k <= 12; k++) begin
            send(5'(k), k == 1);
            if (k == 6) begin
                lat_ref = cyc;
                lat_arm = 1'b1;
            end
        end
        drain(60);
        check("latency_seen", lat_arm, 1'b0);

        // Random values, random ordy, isof pulses with ival low in the gaps
        for (int f = 0; f < 2; f++) begin
            for (int k = 1; k <= 12; k++) begin
                ordy = ($urandom_range(0, 3) != 0);
                if ($urandom_range(0, 4) == 0) begin
                    isof = 1'b1;
                    idle(1);
                    isof = 1'b0;
                end
                send(5'($urandom_range(0, 31)), k == 1);
            end
        end
        ordy = 1'b1;
        drain(80);

        // Restart on a word boundary: nothing pending, no error
        send_frame(6, 1'b0);
        send_frame(12, 1'b1);
        drain(60);
        check("ferr_boundary0", ferr0, m_err[0]);
        check("ferr_boundary1", ferr1, m_err[1]);

        // Restart with 2 LLRs pending on the 12-LLR frame
        send_frame(8, 1'b0);
        send_frame(12, 1'b0);
        drain(60);
        check("ferr_early0", ferr0, m_err[0]);
        check("ferr_early1", ferr1, m_err[1]);
        check("ovf_before0", oovf0, m_ovf[0]);

        // Backpressure: six words offered, four fit, the rest dropped
        ordy = 1'b0;
        for (int f = 0; f < 3; f++) send_frame(12, 1'b0);
        idle(4);
        check("ovf0", oovf0, m_ovf[0]);
        check("ovf1", oovf1, m_ovf[1]);
        check("bp_oval0", ax0.oval, q0.size() != 0);
        check("bp_head0", ax0.odata, q0[0].data);
        idle(3);
        check("bp_hold0", {ax0.odata, ax0.ocnt, ax0.osof, ax0.olast},
              {q0[0].data, q0[0].cnt, q0[0].sof, q0[0].last});
        check("bp_hold1", {ax1.odata, ax1.ocnt, ax1.osof, ax1.olast},
              {q1[0].data, q1[0].cnt, q1[0].sof, q1[0].last});
        xfer[0] = 0;
        xfer[1] = 0;
        ordy    = 1'b1;
        drain(60);
        check("bp_count0", xfer[0], 4);
        check("bp_count1", xfer[1], 4);

        // Reset mid-frame discards the partial word and clears sticky flags
        send(5'd1, 1'b1);
        send(5'd2, 1'b0);
        send(5'd3, 1'b0);
        rst = 1'b1;
        model_reset();
        idle(2);
        check_reset_outputs("midreset_out");
        rst = 1'b0;
        idle(1);
        send_frame(12, 1'b0);
        drain(60);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
